// File: rtl/monitor_decimal.sv
`default_nettype none
// ============================================================================
// Module      : monitor_decimal
// Description : Shows an N-bit unsigned switch value in decimal on a 3-digit,
//               time-multiplexed, common-anode 7-segment display. The switches
//               are registered, converted to hundreds/tens/units by
//               divide/modulo, and one digit at a time is decoded into
//               active-low segment and digit-select drives.
//
//               Define MONITOR_DECIMAL_LEADING_ZERO_BLANK_EN to blank leading
//               zeros. Units is always shown, and all three digits are still
//               scanned.
//
// Ports       : clock_placa  - board clock, rising-edge active
//               reset_placa  - synchronous, active-high reset
//               switches     - N-bit unsigned value to display
//               reg7SEG      - segments, active-low {dp,g,f,e,d,c,b,a}
//               sel_pantalla - digit select, active-low one-hot
//                              {hundreds,tens,units}
// Parameters  : N        - switch width, 1..9
//               SCAN_DIV - clock cycles each digit stays selected, >= 1
// Revision    : 1.0 - initial release
// ============================================================================
module monitor_decimal #(
    parameter int N        = 8,
    parameter int SCAN_DIV = 2
) (
    input  logic         clock_placa,
    input  logic         reset_placa,
    input  logic [N-1:0] switches,
    output logic [7:0]   reg7SEG,
    output logic [2:0]   sel_pantalla
);

    localparam int              c_PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);

    localparam logic [1:0] c_IDX_UNITS    = 2'd0;
    localparam logic [1:0] c_IDX_TENS     = 2'd1;
    localparam logic [1:0] c_IDX_HUNDREDS = 2'd2;

    localparam logic [7:0] c_SEG_BLANK = 8'hFF;
    localparam logic [2:0] c_SEL_NONE  = 3'b111;

    logic [N-1:0]           r_sw;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [1:0]             r_idx;

    logic [8:0] w_value;
    logic [3:0] w_hundreds;
    logic [3:0] w_tens;
    logic [3:0] w_units;
    logic [3:0] w_digit;
    logic [2:0] w_sel;
    logic       w_blank;
    logic [7:0] w_seg;

    // 9 bits always holds 2^N-1 for legal N, so the zero-extension is exact.
    assign w_value    = 9'(r_sw);
    assign w_hundreds = 4'(w_value / 9'd100);
    assign w_tens     = 4'((w_value / 9'd10) % 9'd10);
    assign w_units    = 4'(w_value % 9'd10);

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // The registered outputs follow the current scan index, so after reset
    // units is held for a full SCAN_DIV cycles before tens is selected.
    always_comb begin
        w_digit = w_units;
        w_sel   = 3'b110;
        w_blank = 1'b0;
        case (r_idx)
            c_IDX_TENS: begin
                w_digit = w_tens;
                w_sel   = 3'b101;
`ifdef MONITOR_DECIMAL_LEADING_ZERO_BLANK_EN
                w_blank = (w_hundreds == 4'd0) && (w_tens == 4'd0);
`endif
            end
            c_IDX_HUNDREDS: begin
                w_digit = w_hundreds;
                w_sel   = 3'b011;
`ifdef MONITOR_DECIMAL_LEADING_ZERO_BLANK_EN
                w_blank = (w_hundreds == 4'd0);
`endif
            end
            default: begin
                w_digit = w_units;
                w_sel   = 3'b110;
            end
        endcase
        w_seg = w_blank ? c_SEG_BLANK : seg_decode(w_digit);
    end

    always_ff @(posedge clock_placa) begin
        if (reset_placa) begin
            r_sw         <= '0;
            r_presc      <= '0;
            r_idx        <= c_IDX_UNITS;
            reg7SEG      <= c_SEG_BLANK;
            sel_pantalla <= c_SEL_NONE;
        end else begin
            r_sw         <= switches;
            reg7SEG      <= w_seg;
            sel_pantalla <= w_sel;
            if (r_presc == c_PRESC_MAX) begin
                r_presc <= '0;
                // Index 3 is unreachable; it recovers to units like index 2.
                r_idx   <= (r_idx == c_IDX_UNITS) ? c_IDX_TENS :
                           (r_idx == c_IDX_TENS)  ? c_IDX_HUNDREDS : c_IDX_UNITS;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_monitor_decimal.sv
`default_nettype none
// ============================================================================
// Module      : tb_monitor_decimal
// Description : Scoreboard bench for monitor_decimal (N=8, SCAN_DIV=2).
//               The driver pushes the expected display word for each edge;
//               a monitor pops and compares one sample after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monitor_decimal;

    localparam int N        = 8;
    localparam int SCAN_DIV = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw  = '0;
    logic [7:0]   seg;
    logic [2:0]   sel;

    monitor_decimal #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
        .clock_placa (clk),
        .reset_placa (rst),
        .switches    (sw),
        .reg7SEG     (seg),
        .sel_pantalla(sel)
    );

    always #5 clk = ~clk;

    logic [10:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release, and the switch value
    // the display is currently built from (sampled one edge earlier).
    int m_t  = 0;
    int m_sw = 0;

    function automatic logic [7:0] digit_seg(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return (d >= 0 && d <= 9) ? tbl[d] : 8'hFF;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] s);
        int pos, h, t, u, d;
        logic [7:0] e_seg;
        logic [2:0] e_sel;
        @(negedge clk);
        rst = r;
        sw  = s;
        if (r) begin
            e_seg = 8'hFF;
            e_sel = 3'b111;
            m_t   = 0;
            m_sw  = 0;
        end else begin
            pos = (m_t / SCAN_DIV) % 3;
            h = m_sw / 100;
            t = (m_sw / 10) % 10;
            u = m_sw % 10;
            d = (pos == 0) ? u : (pos == 1) ? t : h;
            e_seg = digit_seg(d);
`ifdef MONITOR_DECIMAL_LEADING_ZERO_BLANK_EN
            if (pos == 2 && h == 0) e_seg = 8'hFF;
            if (pos == 1 && h == 0 && t == 0) e_seg = 8'hFF;
`endif
            e_sel = ~(3'b001 << pos);
            m_t  = m_t + 1;
            m_sw = int'(s);
        end
        exp_q.push_back({e_seg, e_sel});
    endtask

    // Monitor: one sample per edge, away from the edge itself.
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (seg !== e[10:3] || sel !== e[2:0]) begin
                    errors++;
                    $display("FAIL display @%0t: got seg=%h sel=%b, expected seg=%h sel=%b",
                             $time, seg, sel, e[10:3], e[2:0]);
                end
                if (e[2:0] != 3'b111) begin
                    checks++;
                    if ($countones(~sel) != 1) begin
                        errors++;
                        $display("FAIL sel_onehot @%0t: got sel=%b, expected exactly one low bit",
                                 $time, sel);
                    end
                end
            end
        end
    end

    initial begin
        // Reset and all-zero scan.
        repeat (3) step(1'b1, 8'd0);
        repeat (6) step(1'b0, 8'd0);
        // Directed values, two full frames each.
        repeat (12) step(1'b0, 8'd254);
        repeat (12) step(1'b0, 8'd128);
        repeat (12) step(1'b0, 8'd98);
        repeat (3)  step(1'b0, 8'd7);
        // Change 0 -> 255 while units is selected.
        step(1'b1, 8'd0);
        repeat (2) step(1'b0, 8'd0);
        repeat (8) step(1'b0, 8'd255);
        // Reset during tens dwell, then restart at units.
        step(1'b1, 8'd200);
        repeat (3) step(1'b0, 8'd200);
        step(1'b1, 8'd200);
        repeat (8) step(1'b0, 8'd200);
        // Randomized traffic with occasional resets and mid-dwell changes.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] ns;
            ns = ($urandom_range(0, 3) == 0) ? N'($urandom) : sw;
            step(($urandom_range(0, 39) == 0), ns);
        end
        // Drain: bounded wait for the last expectations to be consumed.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
